// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states,
// default memory geometry and small decode helpers.
package load_store_unit_pkg;

   localparam int LSU_MEM_WORDS = 256;
   localparam int LSU_AW        = 8;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_LH  = 3'b001,
      OP_LHU = 3'b010,
      OP_LB  = 3'b011,
      OP_LBU = 3'b100,
      OP_SW  = 3'b101,
      OP_SH  = 3'b110,
      OP_SB  = 3'b111
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RD_WAIT,
      ST_RMW_RD,
      ST_RMW_WAIT,
      ST_WR,
      ST_FIN
   } state_t;

   function automatic logic is_store(input op_t o);
      return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
   endfunction

   // Word ops need a 4-byte aligned address, halfword ops a 2-byte aligned one.
   function automatic logic is_misaligned(input op_t o, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (o)
         OP_LW, OP_SW:          mis = (off != 2'b00);
         OP_LH, OP_LHU, OP_SH:  mis = off[0];
         default:               mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: extracts and extends the addressed byte/half of a
// read word for loads, and merges new store data into a read word for SB/SH.
module load_store_unit_lane_align
   import load_store_unit_pkg::*;
(
   input  op_t         op,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   input  logic [15:0] sdata,
   output logic [31:0] load_val,
   output logic [31:0] merge_val
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{off, 3'b000} +: 8];
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];

      load_val = rdata;
      case (op)
         OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_val = {16'h0000, half_sel};
         OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_val = {24'h000000, byte_sel};
         default: load_val = rdata;
      endcase

      // Untouched lanes keep the value read back from memory.
      merge_val = rdata;
      case (op)
         OP_SB:   merge_val[{off, 3'b000} +: 8] = sdata[7:0];
         OP_SH:   merge_val[{off[1], 4'b0000} +: 16] = sdata;
         default: merge_val = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores via
// read-modify-write, extended loads, fault on misalignment or out-of-range.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int MEM_WORDS = LSU_MEM_WORDS,
   parameter int AW        = LSU_AW
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [2:0]  op,
   input  logic [31:0] byte_addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        fault,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] Address,
   output logic [31:0] Write_data,
   input  logic [31:0] Read_data
);

   state_t      state;
   op_t         op_q;
   logic [1:0]  off_q;
   logic [15:0] sdata_q;

   op_t         req_op;
   logic        req_fault;
   logic [31:0] load_val;
   logic [31:0] merge_val;

   always_comb begin
      req_op    = op_t'(op);
      req_fault = is_misaligned(req_op, byte_addr[1:0]) ||
                  (byte_addr >= 32'(4 * MEM_WORDS));
   end

   load_store_unit_lane_align u_lane_align (
      .op        (op_q),
      .off       (off_q),
      .rdata     (Read_data),
      .sdata     (sdata_q),
      .load_val  (load_val),
      .merge_val (merge_val)
   );

   // All outputs are registered; done/fault/MemRead/MemWrite default to a
   // one-cycle pulse and are re-asserted only by the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         op_q       <= OP_LW;
         off_q      <= 2'b00;
         sdata_q    <= 16'h0000;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         load_data  <= 32'h0000_0000;
         MemRead    <= 1'b0;
         MemWrite   <= 1'b0;
         Address    <= 32'h0000_0000;
         Write_data <= 32'h0000_0000;
      end else begin
         done     <= 1'b0;
         fault    <= 1'b0;
         MemRead  <= 1'b0;
         MemWrite <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req && !busy) begin
                  op_q    <= req_op;
                  off_q   <= byte_addr[1:0];
                  sdata_q <= store_data[15:0];
                  if (req_fault) begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                     fault <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     busy    <= 1'b1;
                     Address <= 32'(byte_addr[AW+1:2]);
                     if (!is_store(req_op)) begin
                        state   <= ST_RD;
                        MemRead <= 1'b1;
                     end else if (req_op == OP_SW) begin
                        state      <= ST_WR;
                        MemWrite   <= 1'b1;
                        Write_data <= store_data;
                     end else begin
                        state   <= ST_RMW_RD;
                        MemRead <= 1'b1;
                     end
                  end
               end
            end
            ST_RD:       state <= ST_RD_WAIT;
            ST_RD_WAIT: begin
               load_data <= load_val;
               state     <= ST_FIN;
               done      <= 1'b1;
               busy      <= 1'b0;
            end
            ST_RMW_RD:   state <= ST_RMW_WAIT;
            ST_RMW_WAIT: begin
               Write_data <= merge_val;
               MemWrite   <= 1'b1;
               state      <= ST_WR;
            end
            ST_WR: begin
               state <= ST_FIN;
               done  <= 1'b1;
               busy  <= 1'b0;
            end
            ST_FIN:      state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle
// corner sequences, and randomized requests against a word-array reference model.
module tb_load_store_unit;

   localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                          LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

   logic        clk, reset, req;
   logic [2:0]  op;
   logic [31:0] byte_addr, store_data;
   logic        busy, done, fault, MemRead, MemWrite;
   logic [31:0] load_data, Address, Write_data, Read_data;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   logic        pl_en;

   int n_checks = 0;
   int n_err    = 0;
   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, stray_fault_cnt = 0, addr_hi_cnt = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_ld;
      logic        chk_ld;
      logic        exp_fault;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   load_store_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .op         (op),
      .byte_addr  (byte_addr),
      .store_data (store_data),
      .busy       (busy),
      .done       (done),
      .load_data  (load_data),
      .fault      (fault),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Address    (Address),
      .Write_data (Write_data),
      .Read_data  (Read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read data memory; preload copies the reference image in one cycle.
   always @(posedge clk) begin
      if (pl_en) begin
         for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
      end else if (MemWrite) begin
         mem[Address[7:0]] <= Write_data;
      end
      if (MemRead) Read_data <= mem[Address[7:0]];
   end

   always @(negedge clk) begin
      if (MemRead) rd_cnt++;
      if (MemWrite) wr_cnt++;
      if (MemRead && MemWrite) both_cnt++;
      if (fault && !done) stray_fault_cnt++;
      if (Address[31:8] != 24'h0) addr_hi_cnt++;
   end

   function automatic int acc_size(input logic [2:0] o);
      if (o == LW || o == SW) return 4;
      if (o == LH || o == LHU || o == SH) return 2;
      return 1;
   endfunction

   function automatic bit op_is_store(input logic [2:0] o);
      return (o == SW) || (o == SH) || (o == SB);
   endfunction

   function automatic bit model_fault(input logic [2:0] o, input logic [31:0] a);
      return (a >= 32'd1024) || ((a % acc_size(o)) != 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] o, input logic [31:0] w, input int off);
      int v;
      int unsigned b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (o)
         LB:  begin v = int'(b); if (v >= 128) v -= 256; return 32'(v); end
         LBU: return 32'(b);
         LH:  begin v = int'(h); if (v >= 32768) v -= 65536; return 32'(v); end
         LHU: return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_store(input logic [2:0] o, input logic [31:0] w,
                                               input int off, input logic [31:0] d);
      logic [31:0] mask;
      int sh;
      if (o == SW) return d;
      if (o == SB) sh = 8 * off; else sh = 16 * (off / 2);
      mask = ((o == SB) ? 32'hFF : 32'hFFFF) << sh;
      return (w & ~mask) | ((d << sh) & mask);
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                                 output int lat, output logic [31:0] ld, output logic flt,
                                 output int nrd, output int nwr, output logic ports_idle);
      int rd0, wr0;
      @(posedge clk); #1;
      rd0 = rd_cnt; wr0 = wr_cnt;
      req = 1'b1; op = o; byte_addr = a; store_data = d;
      lat = -1; ld = '0; flt = 1'b0; ports_idle = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (k == 1) req = 1'b0;
         if (done) begin
            lat = k; ld = load_data; flt = fault;
            ports_idle = !MemRead && !MemWrite;
            break;
         end
      end
      nrd = rd_cnt - rd0;
      nwr = wr_cnt - wr0;
   endtask

   task automatic run_and_check(input string tag, input vec_t v);
      int lat, nrd, nwr;
      logic [31:0] ld;
      logic flt, pidle;
      apply_stimulus(v.op, v.addr, v.data, lat, ld, flt, nrd, nwr, pidle);
      check_output({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
      check_output({tag, " fault"}, 32'(flt), 32'(v.exp_fault));
      if (v.chk_ld) check_output({tag, " load_data"}, ld, v.exp_ld);
      check_output({tag, " reads"}, 32'(nrd), 32'(v.exp_rd));
      check_output({tag, " writes"}, 32'(nwr), 32'(v.exp_wr));
      check_output({tag, " ports idle at done"}, 32'(pidle), 32'd1);
      if (op_is_store(v.op) && !v.exp_fault)
         ref_mem[v.addr / 4] = model_store(v.op, ref_mem[v.addr / 4], int'(v.addr % 4), v.data);
   endtask

   vec_t vecs [12];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int cur_word, accepts, waited;
      logic [31:0] cur_data;
      vec_t rv;

      vecs[0]  = '{LW,  32'd20,   32'h0,        32'h8899AABB, 1'b1, 1'b0, 3, 1, 0};
      vecs[1]  = '{LB,  32'd23,   32'h0,        32'hFFFFFF88, 1'b1, 1'b0, 3, 1, 0};
      vecs[2]  = '{LBU, 32'd23,   32'h0,        32'h00000088, 1'b1, 1'b0, 3, 1, 0};
      vecs[3]  = '{LH,  32'd22,   32'h0,        32'hFFFF8899, 1'b1, 1'b0, 3, 1, 0};
      vecs[4]  = '{LHU, 32'd20,   32'h0,        32'h0000AABB, 1'b1, 1'b0, 3, 1, 0};
      vecs[5]  = '{LB,  32'd20,   32'h0,        32'hFFFFFFBB, 1'b1, 1'b0, 3, 1, 0};
      vecs[6]  = '{SB,  32'd21,   32'h000000CC, 32'h0,        1'b0, 1'b0, 4, 1, 1};
      vecs[7]  = '{LW,  32'd20,   32'h0,        32'h8899CCBB, 1'b1, 1'b0, 3, 1, 0};
      vecs[8]  = '{SW,  32'd22,   32'h11223344, 32'h0,        1'b0, 1'b1, 1, 0, 0};
      vecs[9]  = '{LW,  32'd1024, 32'h0,        32'h0,        1'b0, 1'b1, 1, 0, 0};
      vecs[10] = '{SH,  32'd22,   32'h00001234, 32'h0,        1'b0, 1'b0, 4, 1, 1};
      vecs[11] = '{LW,  32'd20,   32'h0,        32'h1234CCBB, 1'b1, 1'b0, 3, 1, 0};

      req = 1'b0; op = 3'b000; byte_addr = '0; store_data = '0;
      reset = 1'b1; pl_en = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
      ref_mem[5] = 32'h8899AABB;
      pl_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 pl_en = 1'b0;
      check_output("reset flags", {27'h0, busy, done, fault, MemRead, MemWrite}, 32'h0);
      check_output("reset Address", Address, 32'h0);
      check_output("reset Write_data", Write_data, 32'h0);
      check_output("reset load_data", load_data, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) run_and_check($sformatf("vec%0d", i), vecs[i]);
      check_output("word5 after SB/SH", mem[5], 32'h1234CCBB);

      // Reset while an SH sits in RMW_WAIT: no write may reach memory.
      begin
         int wr0;
         @(posedge clk); #1;
         wr0 = wr_cnt;
         req = 1'b1; op = SH; byte_addr = 32'd28; store_data = 32'h0000BEEF;
         @(posedge clk); #1 req = 1'b0;
         @(posedge clk); #1 reset = 1'b1;
         @(posedge clk); #1;
         check_output("mid-RMW reset flags", {27'h0, busy, done, fault, MemRead, MemWrite}, 32'h0);
         check_output("mid-RMW reset Address", Address, 32'h0);
         check_output("mid-RMW reset Write_data", Write_data, 32'h0);
         check_output("mid-RMW reset load_data", load_data, 32'h0);
         reset = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         check_output("mid-RMW reset no write", 32'(wr_cnt - wr0), 32'h0);
         check_output("mid-RMW reset word7", mem[7], ref_mem[7]);
         rv = '{LW, 32'd28, 32'h0, ref_mem[7], 1'b1, 1'b0, 3, 1, 0};
         run_and_check("post-reset LW", rv);
      end

      // req held high across 10 edges with SW: accepts only from IDLE, every third edge.
      @(posedge clk); #1;
      cur_word = 0; cur_data = $urandom; accepts = 0;
      op = SW; byte_addr = 32'(cur_word * 4); store_data = cur_data; req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check_output($sformatf("b2b busy,done k%0d", k), {30'h0, busy, done},
                      {30'h0, (k % 3 == 0), (k % 3 == 1)});
         if (busy) begin
            ref_mem[cur_word] = cur_data;
            accepts++;
            if (cur_word < 2) cur_word++;
            cur_data = $urandom;
            byte_addr = 32'(cur_word * 4);
            store_data = cur_data;
         end
         if (k == 9) req = 1'b0;
      end
      waited = 0;
      while (!done && waited < 10) begin
         @(posedge clk); #1;
         waited++;
      end
      check_output("b2b final done", 32'(done), 32'd1);
      check_output("b2b accept count", 32'(accepts), 32'd4);
      for (int w = 0; w < 3; w++) check_output($sformatf("b2b word%0d", w), mem[w], ref_mem[w]);

      // Randomized requests checked against the reference word array.
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  o;
         logic [31:0] a, d;
         bit f;
         o = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1020, 1100)) : 32'($urandom_range(0, 63));
         d = $urandom;
         f = model_fault(o, a);
         rv.op = o; rv.addr = a; rv.data = d; rv.exp_fault = f;
         rv.chk_ld = !f && !op_is_store(o);
         rv.exp_ld = rv.chk_ld ? model_load(o, ref_mem[a / 4], int'(a % 4)) : 32'h0;
         rv.exp_lat = f ? 1 : (!op_is_store(o) ? 3 : (o == SW ? 2 : 4));
         rv.exp_rd = (f || o == SW) ? 0 : 1;
         rv.exp_wr = (!f && op_is_store(o)) ? 1 : 0;
         run_and_check($sformatf("rand%0d op%0d a%0d", i, o, a), rv);
      end
      @(posedge clk); #1;
      for (int w = 0; w < 16; w++) check_output($sformatf("final word%0d", w), mem[w], ref_mem[w]);

      check_output("MemRead&MemWrite overlap", 32'(both_cnt), 32'h0);
      check_output("fault without done", 32'(stray_fault_cnt), 32'h0);
      check_output("Address upper bits", 32'(addr_hi_cnt), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
